// File: rtl/hash_tte_bucket_nway.sv
// N-way set-associative TTE flow table with exact-match search, insert/update and full-table sweep clear.
// Optional build macro HASH_TTE_STATIC_INIT_EN preloads two static flows after every reset-triggered sweep.
module hash_tte_bucket_nway #(
    parameter int ADDR_W = 10,
    parameter int WAYS   = 2,
    parameter int PORT_W = 16,
    parameter int MAC_W  = 48
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          se_req,
    input  logic [ADDR_W-1:0]             se_hash,
    input  logic [MAC_W-1:0]              se_dmac,
    input  logic [MAC_W-1:0]              se_smac,
    output logic                          se_ack,
    output logic                          se_nak,
    output logic [PORT_W-1:0]             se_result,
    input  logic                          hash_clear,
    input  logic                          hash_update,
    input  logic [ADDR_W-1:0]             hash,
    input  logic [2*MAC_W+PORT_W:0]       flow,
    output logic                          upd_done,
    output logic                          upd_full,
    output logic                          busy
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FLOW_W = 1 + 2 * MAC_W + PORT_W;
    localparam int WSEL_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CLR   = 4'd1,
        ST_S_RD  = 4'd2,
        ST_S_CMP = 4'd3,
        ST_S_RSP = 4'd4,
        ST_U_RD  = 4'd5,
        ST_U_CMP = 4'd6,
        ST_U_WR  = 4'd7
`ifdef HASH_TTE_STATIC_INIT_EN
        ,
        ST_INIT0 = 4'd8,
        ST_INIT1 = 4'd9
`endif
    } state_t;

`ifdef HASH_TTE_STATIC_INIT_EN
    localparam logic [ADDR_W-1:0] INIT0_HASH = ADDR_W'(16'h028E);
    localparam logic [ADDR_W-1:0] INIT1_HASH = ADDR_W'(16'h034D);
    localparam logic [FLOW_W-1:0] INIT0_FLOW = {1'b1, MAC_W'(48'h60beb403644d),
                                                MAC_W'(48'h60beb403060e), PORT_W'(16'h0002)};
    localparam logic [FLOW_W-1:0] INIT1_FLOW = {1'b1, MAC_W'(48'h60beb403060e),
                                                MAC_W'(48'h60beb403644d), PORT_W'(16'h0004)};
`endif

    state_t                 state_r;
    logic [ADDR_W-1:0]      cnt_r;
    logic                   clr_last_r;
    logic [ADDR_W-1:0]      op_hash_r;
    logic [FLOW_W-1:0]      flow_r;
    logic                   hit_r;
    logic [PORT_W-1:0]      hit_port_r;
    logic [WSEL_W-1:0]      way_sel_r;
`ifdef HASH_TTE_STATIC_INIT_EN
    logic                   init_pend_r;
`endif

    logic [FLOW_W-1:0]      mem_r     [WAYS][DEPTH];
    logic [FLOW_W-1:0]      rd_data_r [WAYS];

    logic [WAYS-1:0]        key_hit_s;
    logic [WAYS-1:0]        se_hit_s;
    logic [WAYS-1:0]        free_s;
    logic [PORT_W-1:0]      se_port_s;
    logic [WAYS-1:0]        wr_en_s;
    logic [ADDR_W-1:0]      wr_addr_s;
    logic [FLOW_W-1:0]      wr_data_s;

    function automatic logic valid_of(input logic [FLOW_W-1:0] e);
        return e[FLOW_W-1];
    endfunction

    // Key is {smac, dmac}; both must match for a hit, so one compare covers both.
    function automatic logic [2*MAC_W-1:0] key_of(input logic [FLOW_W-1:0] e);
        return e[FLOW_W-2 -: 2*MAC_W];
    endfunction

    function automatic logic [PORT_W-1:0] port_of(input logic [FLOW_W-1:0] e);
        return e[PORT_W-1:0];
    endfunction

    function automatic logic [WSEL_W-1:0] lowest_way(input logic [WAYS-1:0] vec);
        logic [WSEL_W-1:0] idx;
        idx = {WSEL_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vec[w]) begin
                idx = WSEL_W'(w);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Per-way match/free vectors over the registered read data.
    always_comb begin
        key_hit_s = {WAYS{1'b0}};
        se_hit_s  = {WAYS{1'b0}};
        free_s    = {WAYS{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            key_hit_s[w] = (key_of(rd_data_r[w]) == key_of(flow_r));
            se_hit_s[w]  = valid_of(rd_data_r[w]) & key_hit_s[w];
            free_s[w]    = ~valid_of(rd_data_r[w]);
        end
        se_port_s = port_of(rd_data_r[lowest_way(se_hit_s)]);
    end

    // Single table write port shared by sweep, update and static init.
    always_comb begin
        wr_en_s   = {WAYS{1'b0}};
        wr_addr_s = op_hash_r;
        wr_data_s = flow_r;
        case (state_r)
            ST_CLR: begin
                if (!clr_last_r) begin
                    wr_en_s = {WAYS{1'b1}};
                end else begin
                    wr_en_s = {WAYS{1'b0}};
                end
                wr_addr_s = cnt_r;
                wr_data_s = {FLOW_W{1'b0}};
            end
            ST_U_WR: begin
                wr_en_s[way_sel_r] = 1'b1;
            end
`ifdef HASH_TTE_STATIC_INIT_EN
            ST_INIT0: begin
                wr_en_s[0] = 1'b1;
                wr_addr_s  = INIT0_HASH;
                wr_data_s  = INIT0_FLOW;
            end
            ST_INIT1: begin
                wr_en_s[0] = 1'b1;
                wr_addr_s  = INIT1_HASH;
                wr_data_s  = INIT1_FLOW;
            end
`endif
            default: begin
                wr_en_s = {WAYS{1'b0}};
            end
        endcase
    end

    // Table storage: synchronous write, registered synchronous read at the latched set index.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wr_en_s[w]) begin
                mem_r[w][wr_addr_s] <= wr_data_s;
            end
            rd_data_r[w] <= mem_r[w][op_hash_r];
        end
    end

    // Control FSM with registered pulse outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_CLR;
            cnt_r      <= {ADDR_W{1'b0}};
            clr_last_r <= 1'b0;
            op_hash_r  <= {ADDR_W{1'b0}};
            flow_r     <= {FLOW_W{1'b0}};
            hit_r      <= 1'b0;
            hit_port_r <= {PORT_W{1'b0}};
            way_sel_r  <= {WSEL_W{1'b0}};
            se_ack     <= 1'b0;
            se_nak     <= 1'b0;
            se_result  <= {PORT_W{1'b0}};
            upd_done   <= 1'b0;
            upd_full   <= 1'b0;
            busy       <= 1'b1;
`ifdef HASH_TTE_STATIC_INIT_EN
            init_pend_r <= 1'b1;
`endif
        end else begin
            se_ack   <= 1'b0;
            se_nak   <= 1'b0;
            upd_done <= 1'b0;
            upd_full <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (hash_clear) begin
                        state_r    <= ST_CLR;
                        cnt_r      <= {ADDR_W{1'b0}};
                        clr_last_r <= 1'b0;
                        busy       <= 1'b1;
                    end else if (hash_update) begin
                        op_hash_r <= hash;
                        flow_r    <= flow;
                        state_r   <= ST_U_RD;
                        busy      <= 1'b1;
                    end else if (se_req) begin
                        op_hash_r <= se_hash;
                        flow_r    <= {1'b0, se_smac, se_dmac, {PORT_W{1'b0}}};
                        state_r   <= ST_S_RD;
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                // Counter parks on the last set; one extra cycle then reports completion.
                ST_CLR: begin
                    if (clr_last_r) begin
`ifdef HASH_TTE_STATIC_INIT_EN
                        if (init_pend_r) begin
                            state_r <= ST_INIT0;
                        end else begin
                            state_r  <= ST_IDLE;
                            busy     <= 1'b0;
                            upd_done <= 1'b1;
                        end
`else
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                        upd_done <= 1'b1;
`endif
                    end else if (cnt_r == {ADDR_W{1'b1}}) begin
                        clr_last_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + ADDR_W'(1);
                    end
                end
                ST_S_RD:  state_r <= ST_S_CMP;
                ST_S_CMP: begin
                    hit_r      <= |se_hit_s;
                    hit_port_r <= se_port_s;
                    state_r    <= ST_S_RSP;
                end
                ST_S_RSP: begin
                    if (hit_r) begin
                        se_ack    <= 1'b1;
                        se_result <= hit_port_r;
                    end else begin
                        se_nak <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                ST_U_RD:  state_r <= ST_U_CMP;
                // Existing key wins over a free way so an update never duplicates a flow.
                ST_U_CMP: begin
                    if (|key_hit_s) begin
                        way_sel_r <= lowest_way(key_hit_s);
                        state_r   <= ST_U_WR;
                    end else if (|free_s) begin
                        way_sel_r <= lowest_way(free_s);
                        state_r   <= ST_U_WR;
                    end else begin
                        upd_full <= 1'b1;
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                    end
                end
                ST_U_WR: begin
                    upd_done <= 1'b1;
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                end
`ifdef HASH_TTE_STATIC_INIT_EN
                ST_INIT0: state_r <= ST_INIT1;
                ST_INIT1: begin
                    init_pend_r <= 1'b0;
                    upd_done    <= 1'b1;
                    state_r     <= ST_IDLE;
                    busy        <= 1'b0;
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_tte_bucket_nway.sv
// Scoreboard bench for hash_tte_bucket_nway: reset sweep, search/update, collisions, priority, mid-sweep reset.
module tb_hash_tte_bucket_nway;

    localparam int ADDR_W = 10;
    localparam int WAYS   = 2;
    localparam int PORT_W = 16;
    localparam int MAC_W  = 48;
    localparam int N      = 1 << ADDR_W;
    localparam int FLOW_W = 1 + 2 * MAC_W + PORT_W;
    localparam int CLR_BUSY = N + 1;
`ifdef HASH_TTE_STATIC_INIT_EN
    localparam int RST_BUSY = N + 3;
`else
    localparam int RST_BUSY = N + 1;
`endif

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 se_req;
    logic [ADDR_W-1:0]    se_hash;
    logic [MAC_W-1:0]     se_dmac;
    logic [MAC_W-1:0]     se_smac;
    logic                 se_ack;
    logic                 se_nak;
    logic [PORT_W-1:0]    se_result;
    logic                 hash_clear;
    logic                 hash_update;
    logic [ADDR_W-1:0]    hash;
    logic [FLOW_W-1:0]    flow;
    logic                 upd_done;
    logic                 upd_full;
    logic                 busy;

    typedef struct packed {
        logic              ack;
        logic [PORT_W-1:0] port;
    } sexp_t;

    sexp_t s_q[$];
    logic  u_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    last_lat = 0;

    hash_tte_bucket_nway #(
        .ADDR_W(ADDR_W), .WAYS(WAYS), .PORT_W(PORT_W), .MAC_W(MAC_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .se_req(se_req), .se_hash(se_hash), .se_dmac(se_dmac), .se_smac(se_smac),
        .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result),
        .hash_clear(hash_clear), .hash_update(hash_update), .hash(hash), .flow(flow),
        .upd_done(upd_done), .upd_full(upd_full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_wait busy=%b required 0", busy);
        else n_pass++;
    endtask

    task automatic search(input string nm, input logic [ADDR_W-1:0] h, input logic [MAC_W-1:0] d,
                          input logic [MAC_W-1:0] s, input logic ea, input logic [PORT_W-1:0] ep);
        sexp_t e;
        int    lat;
        wait_idle();
        se_req = 1'b1; se_hash = h; se_dmac = d; se_smac = s;
        e.ack = ea; e.port = ep;
        s_q.push_back(e);
        @(posedge clk); #1;
        se_req = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(se_ack || se_nak) && lat < 20);
        last_lat = lat;
        e = s_q.pop_front();
        n_checks++;
        if ({se_ack, se_nak} !== {e.ack, ~e.ack})
            $display("FAIL %s ack/nak got=%b%b required=%b%b", nm, se_ack, se_nak, e.ack, ~e.ack);
        else n_pass++;
        if (e.ack) begin
            n_checks++;
            if (se_result !== e.port) $display("FAIL %s result got=%h required=%h", nm, se_result, e.port);
            else n_pass++;
        end
    endtask

    task automatic update(input string nm, input logic [ADDR_W-1:0] h, input logic v,
                          input logic [MAC_W-1:0] d, input logic [MAC_W-1:0] s,
                          input logic [PORT_W-1:0] p, input logic ed);
        logic e;
        int   lat;
        wait_idle();
        hash_update = 1'b1; hash = h; flow = {v, s, d, p};
        u_q.push_back(ed);
        @(posedge clk); #1;
        hash_update = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(upd_done || upd_full) && lat < 20);
        e = u_q.pop_front();
        n_checks++;
        if ({upd_done, upd_full} !== {e, ~e})
            $display("FAIL %s done/full got=%b%b required=%b%b", nm, upd_done, upd_full, e, ~e);
        else n_pass++;
    endtask

    task automatic count_busy(input string nm, input int exp_cyc);
        int c;
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (busy && c < 3000);
        n_checks++;
        if (c !== exp_cyc) $display("FAIL %s busy_cycles got=%0d required=%0d", nm, c, exp_cyc);
        else n_pass++;
        n_checks++;
        if (upd_done !== 1'b1) $display("FAIL %s done_pulse got=%b required=1", nm, upd_done);
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string nm);
        n_checks++;
        if ({busy, se_ack, se_nak, upd_done, upd_full} !== 5'b10000)
            $display("FAIL %s flags got=%b required=10000", nm, {busy, se_ack, se_nak, upd_done, upd_full});
        else n_pass++;
        n_checks++;
        if (se_result !== {PORT_W{1'b0}}) $display("FAIL %s se_result got=%h required=0", nm, se_result);
        else n_pass++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rstn = 1'b1;
        count_busy("reset_sweep", RST_BUSY);
        @(posedge clk); #1;
        n_checks++;
        if (upd_done !== 1'b0) $display("FAIL reset_done_width got=%b required=0", upd_done);
        else n_pass++;
        search("empty_search", 10'd5, 48'hA, 48'hB, 1'b0, 16'h0);
    endtask

    task automatic test_basic();
        update("ins_h5", 10'd5, 1'b1, 48'hA, 48'hB, 16'h0010, 1'b1);
        search("hit_h5", 10'd5, 48'hA, 48'hB, 1'b1, 16'h0010);
        n_checks++;
        if (last_lat !== 3) $display("FAIL ack_latency got=%0d required=3", last_lat);
        else n_pass++;
        search("miss_smac", 10'd5, 48'hA, 48'hC, 1'b0, 16'h0);
        n_checks++;
        if (se_result !== 16'h0010) $display("FAIL result_hold got=%h required=0010", se_result);
        else n_pass++;
    endtask

    task automatic test_collision();
        update("ins_k1", 10'd7, 1'b1, 48'h111, 48'h222, 16'h0001, 1'b1);
        update("ins_k2", 10'd7, 1'b1, 48'h333, 48'h444, 16'h0200, 1'b1);
        update("ins_k3_full", 10'd7, 1'b1, 48'h555, 48'h666, 16'h0003, 1'b0);
        update("upd_k1", 10'd7, 1'b1, 48'h111, 48'h222, 16'h0100, 1'b1);
        search("srch_k1", 10'd7, 48'h111, 48'h222, 1'b1, 16'h0100);
        search("srch_k2", 10'd7, 48'h333, 48'h444, 1'b1, 16'h0200);
        search("srch_k3", 10'd7, 48'h555, 48'h666, 1'b0, 16'h0);
        update("del_k1", 10'd7, 1'b0, 48'h111, 48'h222, 16'h0100, 1'b1);
        search("srch_k1_del", 10'd7, 48'h111, 48'h222, 1'b0, 16'h0);
        update("ins_k3_free", 10'd7, 1'b1, 48'h555, 48'h666, 16'h0300, 1'b1);
        search("srch_k3_ins", 10'd7, 48'h555, 48'h666, 1'b1, 16'h0300);
    endtask

    task automatic test_clear_ignored();
        fork
            search("hit_during_clr", 10'd5, 48'hA, 48'hB, 1'b1, 16'h0010);
            begin
                wait (se_req === 1'b1);
                @(posedge clk); #2;
                hash_clear = 1'b1;
                @(posedge clk); #2;
                hash_clear = 1'b0;
            end
        join
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL clear_not_queued busy=%b required=0", busy);
        else n_pass++;
        search("hit_after_clr", 10'd5, 48'hA, 48'hB, 1'b1, 16'h0010);
    endtask

    task automatic test_priority();
        wait_idle();
        se_req = 1'b1; se_hash = 10'd5; se_dmac = 48'hA; se_smac = 48'hB;
        hash_update = 1'b1; hash = 10'd9; flow = {1'b1, 48'hD, 48'hE, 16'h0009};
        hash_clear = 1'b1;
        @(posedge clk); #1;
        se_req = 1'b0; hash_update = 1'b0; hash_clear = 1'b0;
        count_busy("prio_clear", CLR_BUSY);
        search("prio_h5_gone", 10'd5, 48'hA, 48'hB, 1'b0, 16'h0);
        search("prio_upd_dropped", 10'd9, 48'hE, 48'hD, 1'b0, 16'h0);
        search("prio_h7_gone", 10'd7, 48'h333, 48'h444, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid_sweep();
        update("ins_top", 10'h3FF, 1'b1, 48'hA, 48'hB, 16'h0055, 1'b1);
        search("hit_top", 10'h3FF, 48'hA, 48'hB, 1'b1, 16'h0055);
        wait_idle();
        hash_clear = 1'b1;
        @(posedge clk); #1;
        hash_clear = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        count_busy("restart_sweep", RST_BUSY);
        search("top_gone", 10'h3FF, 48'hA, 48'hB, 1'b0, 16'h0);
    endtask

`ifdef HASH_TTE_STATIC_INIT_EN
    task automatic test_static_init();
        search("static0", 10'h28E, 48'h60beb403060e, 48'h60beb403644d, 1'b1, 16'h0002);
        search("static1", 10'h34D, 48'h60beb403644d, 48'h60beb403060e, 1'b1, 16'h0004);
    endtask
`endif

    initial begin
        rstn = 1'b0; se_req = 1'b0; se_hash = '0; se_dmac = '0; se_smac = '0;
        hash_clear = 1'b0; hash_update = 1'b0; hash = '0; flow = '0;
        test_reset();
        test_basic();
        test_collision();
        test_clear_ignored();
        test_priority();
        test_reset_mid_sweep();
`ifdef HASH_TTE_STATIC_INIT_EN
        test_static_init();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
